// File: rtl/uart_tx_serializer_pkg.sv
// Shared UART definitions: FSM state encodings, parity modes and line levels.
// The future receiver imports the same package.
package uart_tx_serializer_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Turns the running XOR of the data bits into the transmitted parity level.
    function automatic logic parity_level(input logic xor_acc, input int mode);
        if (mode == PAR_ODD) begin
            return ~xor_acc;
        end else begin
            return xor_acc;
        end
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: one-entry holding register feeding a baud-tick paced
// start/data/parity/stop frame FSM; back-to-back frames leave with no idle gap.
module uart_tx_serializer
    import uart_tx_serializer_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 serial_out,
    output logic                 busy
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    tx_state_e            state_r,      state_s;
    logic [DATA_BITS-1:0] shifter_r,    shifter_s;
    logic [IDX_W-1:0]     bit_idx_r,    bit_idx_s;
    logic                 stop_cnt_r,   stop_cnt_s;
    logic                 par_acc_r,    par_acc_s;
    logic                 line_r,       line_s;
    logic                 busy_r;
    logic [DATA_BITS-1:0] hold_reg_r;
    logic                 hold_valid_r, hold_valid_s;
    logic                 accept_s;
    logic                 load_s;

    assign tx_ready   = ~hold_valid_r & ~reset;
    assign accept_s   = tx_valid & tx_ready;
    assign serial_out = line_r;
    assign busy       = busy_r;

    // Next-state and next-line computation; nothing moves except on a baud tick.
    always_comb begin
        state_s      = state_r;
        shifter_s    = shifter_r;
        bit_idx_s    = bit_idx_r;
        stop_cnt_s   = stop_cnt_r;
        par_acc_s    = par_acc_r;
        line_s       = line_r;
        hold_valid_s = hold_valid_r;
        load_s       = 1'b0;

        if (baud_tick) begin
            case (state_r)
                S_IDLE: begin
                    if (hold_valid_r) begin
                        load_s = 1'b1;
                    end else begin
                        line_s = LINE_IDLE;
                    end
                end
                S_START: begin
                    line_s    = shifter_r[0];
                    par_acc_s = par_acc_r ^ shifter_r[0];
                    bit_idx_s = {IDX_W{1'b0}};
                    state_s   = S_DATA;
                end
                S_DATA: begin
                    if (bit_idx_r != LAST_IDX) begin
                        shifter_s = shifter_r >> 1;
                        line_s    = shifter_r[1];
                        par_acc_s = par_acc_r ^ shifter_r[1];
                        bit_idx_s = bit_idx_r + IDX_W'(1);
                    end else if (PARITY != PAR_NONE) begin
                        line_s  = parity_level(par_acc_r, PARITY);
                        state_s = S_PARITY;
                    end else begin
                        line_s     = LINE_IDLE;
                        stop_cnt_s = 1'b0;
                        state_s    = S_STOP;
                    end
                end
                S_PARITY: begin
                    line_s     = LINE_IDLE;
                    stop_cnt_s = 1'b0;
                    state_s    = S_STOP;
                end
                S_STOP: begin
                    if ((STOP_BITS == 2) && (stop_cnt_r == 1'b0)) begin
                        stop_cnt_s = 1'b1;
                    end else if (hold_valid_r) begin
                        // Pending byte: chain straight into the next start bit.
                        load_s = 1'b1;
                    end else begin
                        line_s  = LINE_IDLE;
                        state_s = S_IDLE;
                    end
                end
                default: begin
                    line_s  = LINE_IDLE;
                    state_s = S_IDLE;
                end
            endcase

            if (load_s) begin
                line_s       = START_LEVEL;
                shifter_s    = hold_reg_r;
                hold_valid_s = 1'b0;
                par_acc_s    = 1'b0;
                state_s      = S_START;
            end else begin
                hold_valid_s = hold_valid_s;
            end
        end else begin
            state_s = state_r;
        end

        // An accept can only happen while the holding register is empty.
        if (accept_s) begin
            hold_valid_s = 1'b1;
        end else begin
            hold_valid_s = hold_valid_s;
        end
    end

    // FSM, shifter, counters and registered line/busy outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_IDLE;
            shifter_r    <= {DATA_BITS{1'b0}};
            bit_idx_r    <= {IDX_W{1'b0}};
            stop_cnt_r   <= 1'b0;
            par_acc_r    <= 1'b0;
            line_r       <= LINE_IDLE;
            busy_r       <= 1'b0;
            hold_valid_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            shifter_r    <= shifter_s;
            bit_idx_r    <= bit_idx_s;
            stop_cnt_r   <= stop_cnt_s;
            par_acc_r    <= par_acc_s;
            line_r       <= line_s;
            busy_r       <= (state_s != S_IDLE);
            hold_valid_r <= hold_valid_s;
        end
    end

    // Holding register captures the byte on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_reg_r <= {DATA_BITS{1'b0}};
        end else if (accept_s) begin
            hold_reg_r <= tx_data;
        end else begin
            hold_reg_r <= hold_reg_r;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench: four parameterisations driven in parallel, each checked every
// cycle against a frame-level model, plus literal expectations for the directed cases.
module tb_uart_tx_serializer;

    localparam int D0 = 8, P0 = 0, S0 = 1;
    localparam int D1 = 8, P1 = 1, S1 = 1;
    localparam int D2 = 8, P2 = 2, S2 = 1;
    localparam int D3 = 6, P3 = 1, S3 = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       baud_tick;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       so     [4];
    logic       busy_w [4];
    logic       rdy    [4];

    int errors = 0;
    int checks = 0;
    int tick_period = 4;
    bit chk_en = 1'b0;

    // model state
    int          cfg_d [4];
    int          cfg_p [4];
    int          cfg_s [4];
    logic        line_m [4];
    logic        busy_m [4];
    logic        hv_m   [4];
    logic [8:0]  hd_m   [4];
    logic [15:0] fr_m   [4];
    int          len_m  [4];
    int          pos_m  [4];

    logic [19:0] cap_so   [4];
    logic [19:0] cap_busy [4];

    always #5 clk = ~clk;

    uart_tx_serializer #(.DATA_BITS(D0), .PARITY(P0), .STOP_BITS(S0)) u0 (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(rdy[0]), .serial_out(so[0]), .busy(busy_w[0]));
    uart_tx_serializer #(.DATA_BITS(D1), .PARITY(P1), .STOP_BITS(S1)) u1 (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(rdy[1]), .serial_out(so[1]), .busy(busy_w[1]));
    uart_tx_serializer #(.DATA_BITS(D2), .PARITY(P2), .STOP_BITS(S2)) u2 (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(rdy[2]), .serial_out(so[2]), .busy(busy_w[2]));
    uart_tx_serializer #(.DATA_BITS(D3), .PARITY(P3), .STOP_BITS(S3)) u3 (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .tx_data(tx_data[5:0]),
        .tx_valid(tx_valid), .tx_ready(rdy[3]), .serial_out(so[3]), .busy(busy_w[3]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Whole frame as line levels, index 0 leaves first.
    function automatic void build_frame(input logic [8:0] d, input int nd, input int np,
                                        input int ns, output logic [15:0] f, output int n);
        int ones;
        f = 16'h0000;
        n = 0;
        f[n] = 1'b0; n++;
        for (int b = 0; b < nd; b++) begin
            f[n] = d[b]; n++;
        end
        if (np != 0) begin
            ones = $countones(d);
            f[n] = (np == 1) ? ((ones % 2) == 1) : ((ones % 2) == 0); n++;
        end
        for (int s = 0; s < ns; s++) begin
            f[n] = 1'b1; n++;
        end
    endfunction

    // baud tick generator: one-cycle pulse every tick_period clocks
    initial begin
        int tcnt;
        tcnt = 0;
        baud_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tcnt >= tick_period - 1) begin
                tcnt = 0;
                baud_tick = 1'b1;
            end else begin
                tcnt++;
                baud_tick = 1'b0;
            end
        end
    end

    // behavioural model, advanced on every active edge from the inputs seen there
    initial begin
        bit acc;
        cfg_d = '{D0, D1, D2, D3};
        cfg_p = '{P0, P1, P2, P3};
        cfg_s = '{S0, S1, S2, S3};
        for (int i = 0; i < 4; i++) begin
            line_m[i] = 1'b1; busy_m[i] = 1'b0; hv_m[i] = 1'b0; hd_m[i] = 9'h000;
            fr_m[i] = 16'h0000; len_m[i] = 0; pos_m[i] = 0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 4; i++) begin
                if (reset) begin
                    line_m[i] = 1'b1; busy_m[i] = 1'b0; hv_m[i] = 1'b0;
                    pos_m[i] = len_m[i];
                end else begin
                    acc = tx_valid && !hv_m[i];
                    if (baud_tick) begin
                        if (pos_m[i] < len_m[i]) begin
                            line_m[i] = fr_m[i][pos_m[i]];
                            pos_m[i]++;
                        end else if (hv_m[i]) begin
                            build_frame(hd_m[i], cfg_d[i], cfg_p[i], cfg_s[i], fr_m[i], len_m[i]);
                            line_m[i] = fr_m[i][0];
                            pos_m[i] = 1;
                            busy_m[i] = 1'b1;
                            hv_m[i] = 1'b0;
                        end else begin
                            line_m[i] = 1'b1;
                            busy_m[i] = 1'b0;
                        end
                    end
                    if (acc) begin
                        hv_m[i] = 1'b1;
                        hd_m[i] = {1'b0, tx_data} & ((9'h001 << cfg_d[i]) - 9'h001);
                    end
                end
            end
        end
    end

    // compare process: every output of every instance, every cycle
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int i = 0; i < 4; i++) begin
                    check($sformatf("serial_out[u%0d]", i), so[i], line_m[i]);
                    check($sformatf("busy[u%0d]", i), busy_w[i], busy_m[i]);
                    check($sformatf("tx_ready[u%0d]", i), rdy[i], !hv_m[i] && !reset);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // ends 1 time unit after the next edge on which baud_tick was high
    task automatic wait_tick();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            if (baud_tick) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_tick", ok, 1'b1);
        #1;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        tx_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cyc();
            if (!busy_w[0] && !busy_w[1] && !busy_w[2] && !busy_w[3] &&
                rdy[0] && rdy[1] && rdy[2] && rdy[3]) begin
                done = 1'b1;
                break;
            end
        end
        check("wait_idle", done, 1'b1);
    endtask

    // send one byte from idle and capture line/busy at the first 12 ticks
    task automatic send_capture(input logic [7:0] d);
        wait_idle();
        tx_valid = 1'b1;
        tx_data  = d;
        cyc();
        tx_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            wait_tick();
            for (int i = 0; i < 4; i++) begin
                cap_so[i][k]   = so[i];
                cap_busy[i][k] = busy_w[i];
            end
        end
        #1;
    endtask

    initial begin
        logic [15:0] f;
        int          n;
        int          a5_seq [10];
        int          b2b_seq [20];
        int          lows;

        a5_seq  = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        b2b_seq = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1,  0, 0, 1, 0, 1, 0, 1, 0, 1, 1};

        // model pins
        build_frame(9'h0A5, 8, 0, 1, f, n);
        check("model_a5_frame", f[9:0], 10'b1101001010);
        check("model_a5_len", n, 10);
        build_frame(9'h007, 8, 1, 1, f, n);
        check("model_even_par", f[9], 1'b1);
        check("model_even_len", n, 11);
        build_frame(9'h007, 8, 2, 1, f, n);
        check("model_odd_par", f[9], 1'b0);

        // reset and idle
        reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; tick_period = 4;
        cyc();
        chk_en = 1'b1;
        cyc();
        check("ready_in_reset", rdy[0], 1'b0);
        reset = 1'b0;
        repeat (20) cyc();
        check("idle_line", so[0], 1'b1);
        check("idle_busy", busy_w[0], 1'b0);
        check("idle_ready", rdy[0], 1'b1);

        // 0xA5, default frame
        send_capture(8'hA5);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("a5_bit%0d", k), cap_so[0][k], a5_seq[k]);
        end
        check("a5_busy_last_stop", cap_busy[0][9], 1'b1);
        check("a5_busy_after", cap_busy[0][10], 1'b0);

        // 0x07 with even (u1) and odd (u2) parity
        send_capture(8'h07);
        check("even_parity_bit", cap_so[1][9], 1'b1);
        check("odd_parity_bit", cap_so[2][9], 1'b0);
        check("even_busy_tick10", cap_busy[1][10], 1'b1);
        check("even_busy_tick11", cap_busy[1][11], 1'b0);
        check("odd_busy_tick10", cap_busy[2][10], 1'b1);
        check("odd_busy_tick11", cap_busy[2][11], 1'b0);

        // back-to-back 0x55 then 0xAA with tx_valid held
        wait_idle();
        tx_valid = 1'b1; tx_data = 8'h55;
        cyc();
        tx_data = 8'hAA;
        wait_tick();
        cap_so[0][0] = so[0];
        cap_busy[0][0] = busy_w[0];
        #1;
        @(posedge clk);
        #1;
        check("b2b_ready_drop", rdy[0], 1'b0);
        #1;
        tx_valid = 1'b0;
        for (int k = 1; k < 20; k++) begin
            wait_tick();
            cap_so[0][k] = so[0];
            cap_busy[0][k] = busy_w[0];
        end
        for (int k = 0; k < 20; k++) begin
            check($sformatf("b2b_bit%0d", k), cap_so[0][k], b2b_seq[k]);
        end
        check("b2b_busy_contig", cap_busy[0], 20'hFFFFF);
        #1;

        // reset during data bit 3 of 0xFF with a byte pending
        wait_idle();
        tx_valid = 1'b1; tx_data = 8'hFF;
        cyc();
        tx_valid = 1'b0;
        wait_tick();
        #1;
        tx_valid = 1'b1; tx_data = 8'h12;
        cyc();
        tx_valid = 1'b0;
        repeat (4) wait_tick();
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_line_high", so[0], 1'b1);
        check("rst_busy_low", busy_w[0], 1'b0);
        #1;
        reset = 1'b0;
        #1;
        check("rst_hold_cleared", rdy[0], 1'b1);
        lows = 0;
        for (int c = 0; c < 40; c++) begin
            cyc();
            if (so[0] !== 1'b1) lows++;
        end
        check("rst_no_frame", lows, 0);

        // accept on the same edge as a tick in idle
        wait_idle();
        for (int c = 0; c < 20; c++) begin
            if (baud_tick) break;
            cyc();
        end
        tx_valid = 1'b1; tx_data = 8'h3C;
        @(posedge clk);
        #1;
        check("tickacc_no_start", so[0], 1'b1);
        check("tickacc_not_busy", busy_w[0], 1'b0);
        check("tickacc_ready_low", rdy[0], 1'b0);
        #1;
        tx_valid = 1'b0;
        wait_tick();
        check("tickacc_start_bit", so[0], 1'b0);
        check("tickacc_busy", busy_w[0], 1'b1);
        check("tickacc_ready_back", rdy[0], 1'b1);
        #1;

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            if ((c % 500) == 0) tick_period = $urandom_range(2, 7);
            tx_valid = ($urandom_range(0, 3) != 0);
            tx_data  = 8'($urandom);
            reset    = ($urandom_range(0, 399) == 0);
            cyc();
        end
        tx_valid = 1'b0;
        reset = 1'b0;
        repeat (5) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
